// File: rtl/dma_frame_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_frame_fetch_if
// Purpose  : Bundles the two bus-side groups of dma_frame_fetch:
//            - the single-word DMA request/completion bus
//            - the valid/ready word stream towards the AI datapath
// Modports : master - dma_frame_fetch side (drives requests and the stream)
//            slave  - environment side (DMA engine and stream consumer)
// Signals  : dma1_addr/dma1_read/dma1_write/dma1_writedata  request bus
//            dma_readdata/dma_rdy                           completion bus
//            out_data/out_valid/out_ready                   output stream
// Revision : 1.0 - initial release
// ============================================================================
interface dma_frame_fetch_if;
  logic [31:0] dma1_addr;
  logic        dma1_read;
  logic        dma1_write;
  logic [31:0] dma1_writedata;
  logic [31:0] dma_readdata;
  logic        dma_rdy;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output dma1_addr, dma1_read, dma1_write, dma1_writedata,
    output out_data, out_valid,
    input  dma_readdata, dma_rdy,
    input  out_ready
  );

  modport slave (
    input  dma1_addr, dma1_read, dma1_write, dma1_writedata,
    input  out_data, out_valid,
    output dma_readdata, dma_rdy,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/dma_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module   : dma_frame_fetch
// Purpose  : Turns one "fetch N words from base" command into a sequence of
//            single-word DMA reads, buffers the returned words in a
//            first-word-fall-through FIFO and streams them out over
//            valid/ready. At most one DMA read is ever outstanding and a read
//            is only issued when the FIFO has room for its word.
// Ports    : clk, rst (async, active low)
//            cfg_base, cfg_len, start   command, sampled when accepted
//            busy, done                 status (done: one-cycle pulse)
//            bus (master)               DMA request/completion + stream
// Revision : 1.0 - initial release
// ============================================================================
module dma_frame_fetch #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16,
  parameter int ADDR_STEP  = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [31:0]      cfg_base,
  input  wire logic [LEN_W-1:0] cfg_len,
  input  wire logic             start,
  output logic                  busy,
  output logic                  done,
  dma_frame_fetch_if.master     bus
);

  localparam int                 c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);
  localparam logic [31:0]        c_step  = 32'(ADDR_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_addr;
  logic [LEN_W-1:0]   r_rem;
  logic               r_read;
  logic               r_busy;
  logic               r_done;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [31:0]        r_out_data;
  logic               r_out_valid;

  logic               w_push;
  logic               w_pop;
  logic [c_ptr_w-1:0] w_rd_ptr_next;
  logic [c_cnt_w-1:0] w_count_after_pop;
  logic [c_cnt_w-1:0] w_count_next;
  logic               w_space;
  logic [31:0]        w_head_next;
  logic               w_issue;
  logic               w_load;
  logic               w_advance;
  logic               w_done_next;

  // Completions are only meaningful while a read is outstanding; a stale
  // dma_rdy in any other state (e.g. after a reset) is dropped.
  assign w_push            = (r_state == S_WAIT) && bus.dma_rdy;
  assign w_pop             = r_out_valid && bus.out_ready;
  assign w_rd_ptr_next     = r_rd_ptr + c_ptr_w'(w_pop);
  assign w_count_after_pop = r_count - c_cnt_w'(w_pop);
  assign w_count_next      = w_count_after_pop + c_cnt_w'(w_push);

  // Occupancy as it will be when the new read goes out. Nothing else can be
  // pushed until that read completes, so one free slot here is enough.
  assign w_space = (w_count_next < c_depth);

  // Next head word: if the FIFO is empty after this cycle's pop, the only
  // candidate is the word arriving now (bypass around the memory write).
  always_comb begin
    if (w_count_after_pop == '0) begin
      w_head_next = bus.dma_readdata;
    end else begin
      w_head_next = r_mem[w_rd_ptr_next];
    end
  end

  // Next-state logic. dma1_read is registered, so the request for the coming
  // cycle is decided here (w_issue) alongside the transition into REQ.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            w_load       = 1'b1;
            w_state_next = S_REQ;
            w_issue      = w_space;
          end else begin
            w_done_next  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (r_read) begin
          w_state_next = S_WAIT;
        end else begin
          w_issue = w_space;
        end
      end
      S_WAIT: begin
        if (w_push) begin
          w_advance = 1'b1;
          if (r_rem == LEN_W'(1)) begin
            w_state_next = S_DRAIN;
          end else begin
            w_state_next = S_REQ;
            w_issue      = w_space;
          end
        end
      end
      S_DRAIN: begin
        if (w_count_next == '0) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_read  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_read  <= w_issue;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_done_next;
      if (w_load) begin
        r_addr <= cfg_base;
        r_rem  <= cfg_len;
      end else if (w_advance) begin
        r_addr <= r_addr + c_step;
        r_rem  <= r_rem - LEN_W'(1);
      end
    end
  end

  // FIFO storage carries no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.dma_readdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + c_ptr_w'(w_push);
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
      if (w_count_next != '0) begin
        r_out_data <= w_head_next;
      end
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign bus.dma1_addr      = r_addr;
  assign bus.dma1_read      = r_read;
  assign bus.dma1_write     = 1'b0;
  assign bus.dma1_writedata = 32'h0;
  assign bus.out_data       = r_out_data;
  assign bus.out_valid      = r_out_valid;

endmodule
`default_nettype wire
